// File: rtl/spi_settings_bridge_pkg.sv
// Shared definitions for the SPI settings bridge: register map, command layout
// and the SPI configuration word format.
package spi_settings_bridge_pkg;

   typedef enum logic [1:0] {
      REG_DIVIDER = 2'd0,
      REG_CONFIG  = 2'd1,
      REG_PUSH    = 2'd2,
      REG_CLR_OVF = 2'd3
   } reg_off_e;

   localparam int unsigned DIV_W   = 16;
   localparam int unsigned SS_W    = 24;
   localparam int unsigned NBITS_W = 6;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CFG_W   = 32;
   localparam int unsigned CMD_W   = DIV_W + CFG_W + DATA_W;

   localparam int unsigned CMD_DATA_LSB = 0;
   localparam int unsigned CMD_CFG_LSB  = CMD_DATA_LSB + DATA_W;
   localparam int unsigned CMD_DIV_LSB  = CMD_CFG_LSB + CFG_W;

   typedef struct packed {
      logic               dataout_edge;
      logic               datain_edge;
      logic [NBITS_W-1:0] num_bits;
      logic [SS_W-1:0]    slave_sel;
   } spi_cfg_t;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic [DIV_W-1:0]  div,
                                                  input spi_cfg_t          cfg,
                                                  input logic [DATA_W-1:0] data);
      logic [CMD_W-1:0] cmd;
      cmd = '0;
      cmd[CMD_DIV_LSB +: DIV_W]   = div;
      cmd[CMD_CFG_LSB +: CFG_W]   = cfg;
      cmd[CMD_DATA_LSB +: DATA_W] = data;
      return cmd;
   endfunction

endpackage

// File: rtl/spi_settings_bridge_cmd_fifo.sv
// First-word-fall-through command queue with extra-bit pointers; a push while
// full is accepted only when a pop frees a slot in the same cycle.
module axis_cmd_fifo
   import spi_settings_bridge_pkg::*;
#(
   parameter int unsigned WIDTH = CMD_W,
   parameter int unsigned AW    = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_empty_next
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      w_wr_next;
   logic [AW:0]      w_rd_next;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_comb begin
      w_wr_next = r_wr_ptr;
      w_rd_next = r_rd_ptr;
      if (w_do_push) w_wr_next = r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  w_rd_next = r_rd_ptr + (AW+1)'(1);
   end

   assign o_empty_next = (w_wr_next == w_rd_next);
   assign o_data       = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_wr_ptr <= w_wr_next;
         r_rd_ptr <= w_rd_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/spi_settings_bridge.sv
// Settings-bus to AXI-stream bridge: builds SPI commands from register writes,
// queues them, and tracks outstanding transactions against returning readbacks.
module spi_settings_bridge
   import spi_settings_bridge_pkg::*;
#(
   parameter int unsigned BASE    = 0,
   parameter int unsigned DESTW   = 1,
   parameter int unsigned DEST    = 0,
   parameter int unsigned FIFO_AW = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              set_stb,
   input  logic [7:0]        set_addr,
   input  logic [31:0]       set_data,
   output logic [DESTW-1:0]  CONFIG_tdest,
   output logic [CMD_W-1:0]  CONFIG_tdata,
   output logic              CONFIG_tvalid,
   input  logic              CONFIG_tready,
   input  logic [DESTW-1:0]  READBACK_tdest,
   input  logic [31:0]       READBACK_tdata,
   input  logic              READBACK_tvalid,
   output logic              READBACK_tready,
   output logic [31:0]       readback,
   output logic              ready,
   output logic              overflow
);

   localparam logic [FIFO_AW:0] OUT_ONE = (FIFO_AW+1)'(1);

   logic [DIV_W-1:0]  r_divider;
   spi_cfg_t          r_config;
   logic [31:0]       r_readback;
   logic              r_overflow;
   logic              r_ready;
   logic [FIFO_AW:0]  r_outstanding;
   logic [FIFO_AW:0]  w_out_next;

   logic [7:0]        w_rel;
   logic              w_hit;
   reg_off_e          w_off;
   logic              w_wr_div;
   logic              w_wr_cfg;
   logic              w_wr_push;
   logic              w_wr_clr;
   logic [CMD_W-1:0]  w_cmd;
   logic              w_cfg_hs;
   logic              w_rb_match;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_fifo_empty_next;

   assign w_rel     = set_addr - 8'(BASE);
   assign w_hit     = set_stb && !reset && (w_rel[7:2] == 6'd0);
   assign w_off     = reg_off_e'(w_rel[1:0]);
   assign w_wr_div  = w_hit && (w_off == REG_DIVIDER);
   assign w_wr_cfg  = w_hit && (w_off == REG_CONFIG);
   assign w_wr_push = w_hit && (w_off == REG_PUSH);
   assign w_wr_clr  = w_hit && (w_off == REG_CLR_OVF);

   // Only one address per cycle, so a push always sees the pre-cycle registers.
   assign w_cmd = pack_cmd(r_divider, r_config, set_data);

   assign CONFIG_tdest    = DESTW'(DEST);
   assign CONFIG_tvalid   = !w_fifo_empty && !reset;
   assign READBACK_tready = !reset;
   assign w_cfg_hs        = CONFIG_tvalid && CONFIG_tready;
   assign w_rb_match      = READBACK_tvalid && READBACK_tready &&
                            (READBACK_tdest == DESTW'(DEST));

   axis_cmd_fifo #(
      .WIDTH (CMD_W),
      .AW    (FIFO_AW)
   ) u_cmd_fifo (
      .clock        (clock),
      .reset        (reset),
      .i_push       (w_wr_push),
      .i_data       (w_cmd),
      .i_pop        (w_cfg_hs),
      .o_data       (CONFIG_tdata),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty),
      .o_empty_next (w_fifo_empty_next)
   );

   // Counter saturates at both ends; stray readbacks never underflow it.
   always_comb begin
      w_out_next = r_outstanding;
      if (w_cfg_hs && !w_rb_match) begin
         if (r_outstanding != '1) w_out_next = r_outstanding + OUT_ONE;
      end else if (!w_cfg_hs && w_rb_match) begin
         if (r_outstanding != '0) w_out_next = r_outstanding - OUT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_divider     <= '0;
         r_config      <= '0;
         r_readback    <= '0;
         r_overflow    <= 1'b0;
         r_outstanding <= '0;
         r_ready       <= 1'b1;
      end else begin
         if (w_wr_div) r_divider <= set_data[DIV_W-1:0];
         if (w_wr_cfg) r_config  <= spi_cfg_t'(set_data);
         if (w_wr_clr) begin
            r_overflow <= 1'b0;
         end else if (w_wr_push && w_fifo_full && !w_cfg_hs) begin
            r_overflow <= 1'b1;
         end
         if (w_rb_match) r_readback <= READBACK_tdata;
         r_outstanding <= w_out_next;
         r_ready       <= w_fifo_empty_next && (w_out_next == '0);
      end
   end

   assign readback = r_readback;
   assign ready    = r_ready;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_spi_settings_bridge.sv
// Directed table-driven bench for spi_settings_bridge plus hand-written
// sequences for the full/pop overlap and mid-transaction reset cases.
module tb_spi_settings_bridge;

   logic        clock;
   logic        reset;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [0:0]  CONFIG_tdest;
   logic [79:0] CONFIG_tdata;
   logic        CONFIG_tvalid;
   logic        CONFIG_tready;
   logic [0:0]  READBACK_tdest;
   logic [31:0] READBACK_tdata;
   logic        READBACK_tvalid;
   logic        READBACK_tready;
   logic [31:0] readback;
   logic        ready;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   spi_settings_bridge #(
      .BASE    (0),
      .DESTW   (1),
      .DEST    (0),
      .FIFO_AW (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .set_stb         (set_stb),
      .set_addr        (set_addr),
      .set_data        (set_data),
      .CONFIG_tdest    (CONFIG_tdest),
      .CONFIG_tdata    (CONFIG_tdata),
      .CONFIG_tvalid   (CONFIG_tvalid),
      .CONFIG_tready   (CONFIG_tready),
      .READBACK_tdest  (READBACK_tdest),
      .READBACK_tdata  (READBACK_tdata),
      .READBACK_tvalid (READBACK_tvalid),
      .READBACK_tready (READBACK_tready),
      .readback        (readback),
      .ready           (ready),
      .overflow        (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        stb;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        tready;
      logic        rbv;
      logic        rbd;
      logic [31:0] rbdata;
      logic        e_tvalid;
      logic [79:0] e_tdata;
      logic        e_ready;
      logic        e_ovf;
      logic [31:0] e_rb;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic stb, input logic [7:0] addr, input logic [31:0] data,
                               input logic tready, input logic rbv, input logic rbd,
                               input logic [31:0] rbdata, input logic e_tvalid,
                               input logic [79:0] e_tdata, input logic e_ready,
                               input logic e_ovf, input logic [31:0] e_rb);
      vec_t v;
      v.stb = stb; v.addr = addr; v.data = data; v.tready = tready;
      v.rbv = rbv; v.rbd = rbd; v.rbdata = rbdata;
      v.e_tvalid = e_tvalid; v.e_tdata = e_tdata; v.e_ready = e_ready;
      v.e_ovf = e_ovf; v.e_rb = e_rb;
      return v;
   endfunction

   function automatic logic [79:0] cmd(input logic [31:0] d);
      return {16'h0004, 32'h0800_0002, d};
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stb, input logic [7:0] addr, input logic [31:0] data,
                        input logic tready, input logic rbv, input logic rbd,
                        input logic [31:0] rbdata);
      set_stb         = stb;
      set_addr        = addr;
      set_data        = data;
      CONFIG_tready   = tready;
      READBACK_tvalid = rbv;
      READBACK_tdest  = rbd;
      READBACK_tdata  = rbdata;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [79:0] got[$];
   logic [79:0] c1;

   initial begin
      c1 = {16'h0004, 32'h5F00_0001, 32'hA500_0000};

      tv.push_back(mk(1, 8'd0, 32'h0000_0004, 0, 0, 0, 0, 0, '0, 1, 0, 32'h0));
      tv.push_back(mk(1, 8'd1, 32'h5F00_0001, 0, 0, 0, 0, 0, '0, 1, 0, 32'h0));
      tv.push_back(mk(1, 8'd2, 32'hA500_0000, 0, 0, 0, 0, 1, c1, 0, 0, 32'h0));
      tv.push_back(mk(1, 8'd1, 32'h0800_0002, 0, 0, 0, 0, 1, c1, 0, 0, 32'h0));
      tv.push_back(mk(1, 8'd2, 32'h1111_1111, 0, 0, 0, 0, 1, c1, 0, 0, 32'h0));
      tv.push_back(mk(0, 8'd0, 32'h0, 1, 0, 0, 0, 1, cmd(32'h1111_1111), 0, 0, 32'h0));
      tv.push_back(mk(0, 8'd0, 32'h0, 1, 0, 0, 0, 0, '0, 0, 0, 32'h0));
      tv.push_back(mk(0, 8'd0, 32'h0, 0, 1, 0, 32'h1234_5678, 0, '0, 0, 0, 32'h1234_5678));
      tv.push_back(mk(0, 8'd0, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 0, '0, 0, 0, 32'h1234_5678));
      tv.push_back(mk(0, 8'd0, 32'h0, 0, 1, 0, 32'hCAFE_F00D, 0, '0, 1, 0, 32'hCAFE_F00D));
      tv.push_back(mk(1, 8'd3, 32'h0, 0, 0, 0, 0, 0, '0, 1, 0, 32'hCAFE_F00D));
      tv.push_back(mk(1, 8'd4, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, '0, 1, 0, 32'hCAFE_F00D));
      tv.push_back(mk(0, 8'd0, 32'h0, 0, 1, 0, 32'h0BAD_F00D, 0, '0, 1, 0, 32'h0BAD_F00D));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(1, 8'd2, 32'h100 + i, 0, 0, 0, 0, 1, cmd(32'h100), 0, 0, 32'h0BAD_F00D));
      tv.push_back(mk(1, 8'd2, 32'h104, 0, 0, 0, 0, 1, cmd(32'h100), 0, 1, 32'h0BAD_F00D));
      tv.push_back(mk(1, 8'd3, 32'h0, 0, 0, 0, 0, 1, cmd(32'h100), 0, 0, 32'h0BAD_F00D));
      for (int i = 1; i < 4; i++)
         tv.push_back(mk(0, 8'd0, 32'h0, 1, 0, 0, 0, 1, cmd(32'h100 + i), 0, 0, 32'h0BAD_F00D));
      tv.push_back(mk(0, 8'd0, 32'h0, 1, 0, 0, 0, 0, '0, 0, 0, 32'h0BAD_F00D));
      tv.push_back(mk(0, 8'd0, 32'h0, 1, 0, 0, 0, 0, '0, 0, 0, 32'h0BAD_F00D));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(0, 8'd0, 32'h0, 0, 1, 0, 32'h200 + i, 0, '0, (i == 3), 0, 32'h200 + i));

      // Reset phase
      reset = 1'b1;
      drive(0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      step();
      chk("rst_tvalid", 80'(CONFIG_tvalid), 80'(0));
      chk("rst_rbtready", 80'(READBACK_tready), 80'(0));
      step();
      step();
      reset = 1'b0;
      step();
      chk("post_rst_ready", 80'(ready), 80'(1));
      chk("post_rst_tvalid", 80'(CONFIG_tvalid), 80'(0));
      chk("post_rst_ovf", 80'(overflow), 80'(0));
      chk("post_rst_rb", 80'(readback), 80'(0));
      chk("tdest_const", 80'(CONFIG_tdest), 80'(0));

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].stb, tv[i].addr, tv[i].data, tv[i].tready, tv[i].rbv, tv[i].rbd, tv[i].rbdata);
         step();
         chk($sformatf("v%0d_tvalid", i), 80'(CONFIG_tvalid), 80'(tv[i].e_tvalid));
         if (tv[i].e_tvalid)
            chk($sformatf("v%0d_tdata", i), CONFIG_tdata, tv[i].e_tdata);
         chk($sformatf("v%0d_ready", i), 80'(ready), 80'(tv[i].e_ready));
         chk($sformatf("v%0d_ovf", i), 80'(overflow), 80'(tv[i].e_ovf));
         chk($sformatf("v%0d_rb", i), 80'(readback), 80'(tv[i].e_rb));
         chk($sformatf("v%0d_rbtready", i), 80'(READBACK_tready), 80'(1));
      end

      // Full FIFO with a push coincident with a pop
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'd2, 32'h300 + i, 0, 0, 0, 32'h0);
         step();
      end
      got.delete();
      drive(1, 8'd2, 32'h304, 1, 0, 0, 32'h0);
      if (CONFIG_tvalid) got.push_back(CONFIG_tdata);
      step();
      chk("ovl_ovf", 80'(overflow), 80'(0));
      drive(0, 8'd0, 32'h0, 1, 0, 0, 32'h0);
      for (int n = 0; n < 20 && CONFIG_tvalid; n++) begin
         got.push_back(CONFIG_tdata);
         step();
      end
      chk("ovl_drained", 80'(CONFIG_tvalid), 80'(0));
      chk("ovl_beats", 80'(got.size()), 80'(5));
      for (int i = 0; i < 5 && i < got.size(); i++)
         chk($sformatf("ovl_beat%0d", i), got[i], cmd(32'h300 + i));
      chk("ovl_ovf_end", 80'(overflow), 80'(0));

      // Leave one transaction outstanding, queue two, then reset
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'd0, 32'h0, 0, 1, 0, 32'h500 + i);
         step();
      end
      drive(0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      step();
      chk("pre_rst_ready", 80'(ready), 80'(0));
      drive(1, 8'd2, 32'h400, 0, 0, 0, 32'h0);
      step();
      drive(1, 8'd2, 32'h401, 0, 0, 0, 32'h0);
      step();
      chk("pre_rst_tvalid", 80'(CONFIG_tvalid), 80'(1));
      reset = 1'b1;
      drive(1, 8'd0, 32'h0000_FFFF, 1, 0, 0, 32'h0);
      step();
      chk("mid_rst_tvalid", 80'(CONFIG_tvalid), 80'(0));
      chk("mid_rst_rbtready", 80'(READBACK_tready), 80'(0));
      chk("mid_rst_rb", 80'(readback), 80'(0));
      drive(1, 8'd1, 32'hFFFF_FFFF, 1, 0, 0, 32'h0);
      step();
      reset = 1'b0;
      drive(0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      step();
      chk("rst2_tvalid", 80'(CONFIG_tvalid), 80'(0));
      chk("rst2_ready", 80'(ready), 80'(1));
      chk("rst2_ovf", 80'(overflow), 80'(0));
      drive(0, 8'd0, 32'h0, 0, 1, 0, 32'h55AA_55AA);
      step();
      chk("stray_rb", 80'(readback), 80'(32'h55AA_55AA));
      chk("stray_ready", 80'(ready), 80'(1));
      drive(0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      step();
      chk("stray_ready2", 80'(ready), 80'(1));
      drive(1, 8'd2, 32'h77, 0, 0, 0, 32'h0);
      step();
      chk("rst2_cmd_tvalid", 80'(CONFIG_tvalid), 80'(1));
      chk("rst2_cmd_tdata", CONFIG_tdata, {16'h0, 32'h0, 32'h77});
      chk("rst2_cmd_ready", 80'(ready), 80'(0));
      drive(0, 8'd0, 32'h0, 0, 0, 0, 32'h0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
